// File: rtl/booking_req_dispatcher_if.sv
// Signal bundle between the booking request dispatcher, its upstream client
// and the booking core. The dispatcher connects through the slave modport.
interface booking_req_dispatcher_if #(
  parameter int DEPTH = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_train_id;
  logic [2:0]               req_src;
  logic [2:0]               req_dest;
  logic [3:0]               req_tickets;
  logic                     book_req;
  logic                     train_id;
  logic [2:0]               src;
  logic [2:0]               dest;
  logic [3:0]               num_tickets;
  logic                     success;
  logic [9:0]               fare;
  logic                     fault_flag;
  logic                     heal_trigger;
  logic                     resp_valid;
  logic [1:0]               resp_code;
  logic [9:0]               resp_fare;
  logic [$clog2(DEPTH):0]   pending;
  logic                     busy;

  modport slave (
    input  req_valid, req_train_id, req_src, req_dest, req_tickets,
    input  success, fare, fault_flag, heal_trigger,
    output req_ready, book_req, train_id, src, dest, num_tickets,
    output resp_valid, resp_code, resp_fare, pending, busy
  );

  modport master (
    output req_valid, req_train_id, req_src, req_dest, req_tickets,
    output success, fare, fault_flag, heal_trigger,
    input  req_ready, book_req, train_id, src, dest, num_tickets,
    input  resp_valid, resp_code, resp_fare, pending, busy
  );
endinterface

// File: rtl/booking_req_dispatcher.sv
// Queues booking requests, validates the head, issues it to the booking core
// with timeout/retry handling, and returns exactly one response per request.
module booking_req_dispatcher #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  booking_req_dispatcher_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {
    RC_OK      = 2'b00,
    RC_INVALID = 2'b01,
    RC_TIMEOUT = 2'b10,
    RC_FAULT   = 2'b11
  } resp_code_t;

  typedef struct packed {
    logic       train_id;
    logic [2:0] src;
    logic [2:0] dest;
    logic [3:0] tickets;
  } req_t;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state,     w_state_nxt;
  logic [7:0]    r_timer,     w_timer_nxt;
  logic [2:0]    r_retry,     w_retry_nxt;
  resp_code_t    r_resp_code, w_resp_code_nxt;
  logic [9:0]    r_resp_fare, w_resp_fare_nxt;

  logic w_full, w_empty, w_push, w_pop;
  logic w_head_invalid, w_timeout, w_retry_left, w_core_unhealthy;
  req_t w_head;

  assign w_full           = (r_count == (AW+1)'(DEPTH));
  assign w_empty          = (r_count == '0);
  assign w_push           = bus.req_valid && !w_full;
  assign w_pop            = (r_state == S_RESP);
  assign w_head           = r_mem[r_rd_ptr];
  assign w_head_invalid   = (w_head.src >= w_head.dest) || (w_head.tickets == 4'd0);
  assign w_timeout        = (r_timer == 8'(TIMEOUT - 1));
  assign w_retry_left     = (r_retry < 3'(MAX_RETRY));
  assign w_core_unhealthy = bus.fault_flag || bus.heal_trigger;

  // NOTE: the storage array carries no reset; occupancy is defined entirely
  // by the pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{train_id: bus.req_train_id, src: bus.req_src,
                           dest: bus.req_dest, tickets: bus.req_tickets};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_retry     <= '0;
      r_resp_code <= RC_OK;
      r_resp_fare <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry     <= w_retry_nxt;
      r_resp_code <= w_resp_code_nxt;
      r_resp_fare <= w_resp_fare_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_retry_nxt     = r_retry;
    w_resp_code_nxt = r_resp_code;
    w_resp_fare_nxt = r_resp_fare;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head_invalid) begin
            w_state_nxt     = S_RESP;
            w_resp_code_nxt = RC_INVALID;
            w_resp_fare_nxt = '0;
          end else if (!w_core_unhealthy) begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + 8'd1;
        if (bus.success) begin
          w_state_nxt     = S_RESP;
          w_resp_code_nxt = RC_OK;
          w_resp_fare_nxt = bus.fare;
        end else if (bus.fault_flag || w_timeout) begin
          // Fault outranks timeout when both land in the same cycle.
          if (w_retry_left) begin
            w_retry_nxt = r_retry + 3'd1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt     = S_RESP;
            w_resp_code_nxt = bus.fault_flag ? RC_FAULT : RC_TIMEOUT;
            w_resp_fare_nxt = '0;
          end
        end
      end
      S_RESP: begin
        w_retry_nxt     = '0;
        w_resp_code_nxt = RC_OK;
        w_resp_fare_nxt = '0;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Head fields stay put through ISSUE/WAIT because only RESP pops.
  assign bus.req_ready   = !w_full;
  assign bus.book_req    = (r_state == S_ISSUE);
  assign bus.resp_valid  = (r_state == S_RESP);
  assign bus.resp_code   = r_resp_code;
  assign bus.resp_fare   = r_resp_fare;
  assign bus.train_id    = w_head.train_id;
  assign bus.src         = w_head.src;
  assign bus.dest        = w_head.dest;
  assign bus.num_tickets = w_head.tickets;
  assign bus.pending     = r_count;
  assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_booking_req_dispatcher.sv
// Self-checking bench for booking_req_dispatcher: scoreboard of expected
// responses plus a reactive booking-core model.
module tb_booking_req_dispatcher;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booking_req_dispatcher_if #(.DEPTH(4)) bus ();

  booking_req_dispatcher #(.DEPTH(4), .TIMEOUT(8), .MAX_RETRY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard entries are {resp_code, resp_fare}.
  logic [11:0] sb[$];
  int book_cycs[$];
  int resp_cycs[$];
  int n_book = 0;
  int n_resp = 0;

  // Reactive core model; attempt numbers are relative to att_base.
  int          attempt   = 0;
  int          wcyc      = -1000000;
  int          att_base  = 0;
  int          succ_att  = 0;
  int          succ_cyc  = 1;
  int          fault_att = 0;
  int          fault_cyc = 1;
  logic [9:0]  succ_fare = '0;

  always @(posedge clk) begin
    #1;
    if (bus.book_req) begin
      attempt++;
      wcyc = 0;
    end else begin
      wcyc++;
    end
    bus.success    = (succ_att != 0) && ((succ_att == -1) || (succ_att == attempt - att_base))
                     && (wcyc == succ_cyc);
    bus.fare       = bus.success ? succ_fare : 10'd0;
    bus.fault_flag = (fault_att != 0) && ((fault_att == -1) || (fault_att == attempt - att_base))
                     && (wcyc == fault_cyc);
  end

  // Output monitor, sampled on the falling edge.
  logic        in_flight = 1'b0;
  logic [10:0] cap_fields;
  logic [11:0] exp_resp;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 1'b0;
    end else begin
      if (bus.book_req) begin
        n_book++;
        book_cycs.push_back(cyc);
        in_flight  = 1'b1;
        cap_fields = {bus.train_id, bus.src, bus.dest, bus.num_tickets};
      end else if (in_flight) begin
        check("fields_stable", 32'({bus.train_id, bus.src, bus.dest, bus.num_tickets}),
              32'(cap_fields));
      end
      if (bus.resp_valid) begin
        n_resp++;
        resp_cycs.push_back(cyc);
        in_flight = 1'b0;
        check("resp_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_resp = sb.pop_front();
          check("resp_code", 32'(bus.resp_code), 32'(exp_resp[11:10]));
          check("resp_fare", 32'(bus.resp_fare), 32'(exp_resp[9:0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int book_at(input int idx);
    return (idx < book_cycs.size()) ? book_cycs[idx] : -1;
  endfunction

  function automatic int resp_at(input int idx);
    return (idx < resp_cycs.size()) ? resp_cycs[idx] : -1;
  endfunction

  task automatic configure(input int sa, input int sc, input int fa, input int fc,
                           input logic [9:0] f);
    att_base  = attempt;
    succ_att  = sa;
    succ_cyc  = sc;
    fault_att = fa;
    fault_cyc = fc;
    succ_fare = f;
    book_cycs.delete();
    resp_cycs.delete();
  endtask

  // Drives one request for one cycle; the push edge is the next posedge.
  task automatic send(input logic tr, input logic [2:0] s, input logic [2:0] d,
                      input logic [3:0] t, input logic [1:0] code, input logic [9:0] f,
                      output int push_edge, output logic acc);
    bus.req_valid    = 1'b1;
    bus.req_train_id = tr;
    bus.req_src      = s;
    bus.req_dest     = d;
    bus.req_tickets  = t;
    acc              = bus.req_ready;
    push_edge        = cyc + 1;
    if (acc) sb.push_back({code, f});
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resps(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && n_resp < target; i++) step();
    check(tag, 32'(n_resp), 32'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   e, fall, b0, r0;
  logic acc;

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_train_id = 1'b0;
    bus.req_src      = '0;
    bus.req_dest     = '0;
    bus.req_tickets  = '0;
    bus.heal_trigger = 1'b0;
    bus.success      = 1'b0;
    bus.fare         = '0;
    bus.fault_flag   = 1'b0;
    repeat (3) step();

    check("rst_pending",    32'(bus.pending),    32'd0);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_book_req",   32'(bus.book_req),   32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_code",  32'(bus.resp_code),  32'd0);
    check("rst_resp_fare",  32'(bus.resp_fare),  32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    rst_n = 1'b1;
    step();

    // Normal booking, success in the 2nd WAIT cycle with fare 60.
    configure(1, 2, 0, 1, 10'd60);
    b0 = n_book; r0 = n_resp;
    send(1'b0, 3'd0, 3'd2, 4'd3, 2'b00, 10'd60, e, acc);
    wait_resps("t1_resp_count", r0 + 1, 40);
    check("t1_books",       32'(n_book - b0), 32'd1);
    check("t1_issue_lat",   32'(book_at(0)),  32'(e + 1));
    check("t1_resp_lat",    32'(resp_at(0)),  32'(e + 4));
    check("t1_pending",     32'(bus.pending), 32'd0);

    // Two invalid requests: src >= dest, then zero tickets.
    configure(-1, 1, 0, 1, 10'd5);
    b0 = n_book; r0 = n_resp;
    send(1'b0, 3'd3, 3'd1, 4'd2, 2'b01, 10'd0, e, acc);
    send(1'b1, 3'd0, 3'd1, 4'd0, 2'b01, 10'd0, e, acc);
    wait_resps("t2_resp_count", r0 + 2, 40);
    check("t2_books",       32'(n_book - b0), 32'd0);

    // Guard hold: heal_trigger high for 5 cycles with a valid request queued.
    configure(1, 1, 0, 1, 10'd100);
    b0 = n_book; r0 = n_resp;
    bus.heal_trigger = 1'b1;
    send(1'b1, 3'd1, 3'd5, 4'd2, 2'b00, 10'd100, e, acc);
    repeat (3) step();
    check("t3_hold_books",  32'(n_book - b0), 32'd0);
    step();
    bus.heal_trigger = 1'b0;
    fall = cyc;
    wait_resps("t3_resp_count", r0 + 1, 40);
    check("t3_issue_after", 32'(book_at(0)),  32'(fall + 1));

    // Timeout on every attempt: 3 issues, 8 WAIT cycles each, code 10.
    configure(0, 1, 0, 1, 10'd0);
    b0 = n_book; r0 = n_resp;
    send(1'b0, 3'd1, 3'd4, 4'd1, 2'b10, 10'd0, e, acc);
    wait_resps("t4_resp_count", r0 + 1, 80);
    check("t4_books",       32'(n_book - b0), 32'd3);
    check("t4_gap1",        32'(book_at(1) - book_at(0)), 32'd10);
    check("t4_gap2",        32'(book_at(2) - book_at(1)), 32'd10);
    check("t4_resp_lat",    32'(resp_at(0) - book_at(2)), 32'd9);

    // Fault in 3rd WAIT cycle of attempt 1, success on attempt 2.
    configure(2, 1, 1, 3, 10'd77);
    b0 = n_book; r0 = n_resp;
    send(1'b1, 3'd0, 3'd7, 4'd15, 2'b00, 10'd77, e, acc);
    wait_resps("t5_resp_count", r0 + 1, 60);
    check("t5_books",       32'(n_book - b0), 32'd2);
    check("t5_gap",         32'(book_at(1) - book_at(0)), 32'd5);

    // Fault on every attempt: retries exhausted, code 11.
    configure(0, 1, -1, 2, 10'd0);
    b0 = n_book; r0 = n_resp;
    send(1'b0, 3'd2, 3'd6, 4'd4, 2'b11, 10'd0, e, acc);
    wait_resps("t5b_resp_count", r0 + 1, 60);
    check("t5b_books",      32'(n_book - b0), 32'd3);
    check("t5b_gap",        32'(book_at(2) - book_at(1)), 32'd4);

    // Back-to-back requests: second issue 2 cycles after the first RESP.
    configure(-1, 1, 0, 1, 10'd200);
    b0 = n_book; r0 = n_resp;
    send(1'b0, 3'd0, 3'd3, 4'd1, 2'b00, 10'd200, e, acc);
    send(1'b1, 3'd4, 3'd5, 4'd9, 2'b00, 10'd200, e, acc);
    wait_resps("t7_resp_count", r0 + 2, 60);
    check("t7_b2b_gap",     32'(book_at(1) - resp_at(0)), 32'd2);
    check("sb_drained",     32'(sb.size()), 32'd0);

    // FIFO full with 5 back-to-back pushes, then reset during WAIT.
    configure(0, 1, 0, 1, 10'd0);
    r0 = n_resp;
    for (int i = 0; i < 5; i++) begin
      send(1'(i), 3'd0, 3'd1, 4'(i + 1), 2'b10, 10'd0, e, acc);
      if (i == 3) begin
        check("t6_ready_full",  32'(bus.req_ready), 32'd0);
        check("t6_pending_4",   32'(bus.pending),   32'd4);
      end
    end
    check("t6_5th_rejected",  32'(acc),         32'd0);
    check("t6_still_4",       32'(bus.pending), 32'd4);
    check("t6_in_wait",       32'({bus.busy, bus.book_req, bus.resp_valid}), 32'b100);
    rst_n = 1'b0;
    step();
    check("t6_rst_pending",   32'(bus.pending),  32'd0);
    check("t6_rst_busy",      32'(bus.busy),     32'd0);
    check("t6_rst_book_req",  32'(bus.book_req), 32'd0);
    check("t6_rst_ready",     32'(bus.req_ready), 32'd1);
    sb.delete();
    rst_n = 1'b1;
    repeat (20) step();
    check("t6_no_resp",       32'(n_resp - r0), 32'd0);
    check("t6_idle_after",    32'(bus.busy),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
